ncl_wavefront_injector: RTL and testbench

- Clocked front end that feeds the dual-rail input buffers of the 32-bit NCL fullword adder pipeline. It replaces the file-driven testbench source.
- Accepts single-rail A/B operand pairs from synchronous logic, queues them, and presents them as alternating DATA/NULL dual-rail wavefronts.
- Wavefront sequencing is paced by the adder's four-phase completion/acknowledge signal.
- It is the sync-to-NCL boundary stage directly upstream of the adder.

---
 rtl/ncl_pkg.sv | 30 +++
 rtl/ncl_operand_fifo.sv | 56 +++++
 rtl/ncl_wavefront_injector.sv | 118 +++++++++++
 tb/tb_ncl_wavefront_injector.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared NCL definitions: dual-rail pair codes, injector states, encoder.
// Latency: none (pure definitions and combinational helper).
// Backpressure: not applicable.
package ncl_pkg;

   // Dual-rail pair codes; 2'b11 is illegal and never produced.
   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ZERO = 2'b01;

   // Widest single-rail operand the encoder handles; callers size-cast in/out.
   localparam int DR_MAX_W = 64;

   typedef enum logic [1:0] {
      S_NULL_WAIT,
      S_DATA,
      S_NULL_ACK
   } wave_state_t;

   // Single-rail to dual-rail: bit i lands in pair [2i+1:2i].
   function automatic logic [2*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] sr);
      logic [2*DR_MAX_W-1:0] dr;
      dr = '0;
      for (int i = 0; i < DR_MAX_W; i++) begin
         dr[2*i +: 2] = sr[i] ? DR_ONE : DR_ZERO;
      end
      return dr;
   endfunction

endpackage

// File: rtl/ncl_operand_fifo.sv
// Synchronous DEPTH-entry FIFO holding packed operand pairs.
// Latency: a push is visible at the head one cycle later; head reads are combinational.
// Backpressure: pushes while full are dropped (even with a same-cycle pop); pops while empty are ignored.
module ncl_operand_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     init_n,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/ncl_wavefront_injector.sv
// Sync-to-NCL boundary: queues single-rail operand pairs and issues DATA/NULL dual-rail wavefronts.
// Latency: a ki edge reaches a_dr/b_dr in SYNC_STAGES+1 cycles; all outputs registered.
// Backpressure: in_ready = !full; wavefront pacing follows the adder's four-phase ki handshake.
module ncl_wavefront_injector
   import ncl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic               clk,
   input  logic               init_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [2*WIDTH-1:0] a_dr,
   output logic [2*WIDTH-1:0] b_dr,
   input  logic               ki,
   output logic               busy,
   output logic [15:0]        wave_count,
   output logic               timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

   logic [SYNC_STAGES-1:0]  ki_sync;
   logic                    kis;
   wave_state_t             state_q;
   wave_state_t             state_d;
   logic                    load;
   logic                    retire;
   logic [TW-1:0]           to_cnt;
   logic [2*WIDTH-1:0]      head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;

   assign kis      = ki_sync[SYNC_STAGES-1];
   assign in_ready = !fifo_full;
   assign busy     = (fifo_count != '0) || (state_q != S_NULL_WAIT);

   ncl_operand_fifo #(
      .W     (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .init_n   (init_n),
      .push     (in_valid),
      .push_dat ({in_a, in_b}),
      .pop      (load),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // ki is asynchronous to clk: pass it through a plain flop chain.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) ki_sync <= '0;
      else         ki_sync <= {ki_sync[SYNC_STAGES-2:0], ki};
   end

   // Handshake sequencing: issue DATA on request-for-data, retire on request-for-null.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_NULL_WAIT: if (kis && !fifo_empty) begin
            load    = 1'b1;
            state_d = S_DATA;
         end
         S_DATA: if (!kis) begin
            retire  = 1'b1;
            state_d = S_NULL_ACK;
         end
         S_NULL_ACK: if (kis) state_d = S_NULL_WAIT;
         default: state_d = S_NULL_WAIT;
      endcase
   end

   // State, wavefront registers and completed-wave counter; whole bus switches on one edge.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q    <= S_NULL_WAIT;
         a_dr       <= '0;
         b_dr       <= '0;
         wave_count <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_dr <= (2*WIDTH)'(dr_encode(DR_MAX_W'(head[2*WIDTH-1:WIDTH])));
            b_dr <= (2*WIDTH)'(dr_encode(DR_MAX_W'(head[WIDTH-1:0])));
         end else if (retire) begin
            a_dr <= '0;
            b_dr <= '0;
         end
         if (retire) wave_count <= wave_count + 16'd1;
      end
   end

   // Per-phase watchdog: idle in S_NULL_WAIT, restarts on every state change, sticky error.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_d != state_q || state_q == S_NULL_WAIT) to_cnt <= '0;
         else if (to_cnt != TO_LIM)                        to_cnt <= to_cnt + 1'b1;
         if (state_q != S_NULL_WAIT && state_d == state_q && to_cnt == TO_LIM - 1'b1)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ncl_wavefront_injector.sv
module tb_ncl_wavefront_injector;

   logic        clk = 1'b0;
   logic        init_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [63:0] a_dr;
   logic [63:0] b_dr;
   logic        ki;
   logic        busy;
   logic [15:0] wave_count;
   logic        timeout_err;

   logic        model_en = 1'b0;
   logic        ki_man = 1'b0;
   logic        ki_auto = 1'b1;

   int n_checks = 0;
   int n_fail = 0;

   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] last_a = '0;
   logic [63:0] last_b = '0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] ea;
      logic [63:0] eb;
   } vec_t;
   vec_t tbl[5];

   ncl_wavefront_injector #(
      .WIDTH(32), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(16)
   ) dut (
      .clk(clk), .init_n(init_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .a_dr(a_dr), .b_dr(b_dr), .ki(ki),
      .busy(busy), .wave_count(wave_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   assign ki = model_en ? ki_auto : ki_man;

   // Adder completion model: request NULL once every pair of both operands holds data.
   always @(a_dr, b_dr) begin
      logic full_dat;
      full_dat = 1'b1;
      for (int i = 0; i < 32; i++)
         if (a_dr[2*i +: 2] == 2'b00 || b_dr[2*i +: 2] == 2'b00) full_dat = 1'b0;
      ki_auto <= #5 !full_dat;
   end

   function automatic logic [31:0] dec(input logic [63:0] dr);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = dr[2*i+1];
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Wavefront monitor: on every output change, no 11 pairs and no partial wavefront.
   always @(negedge clk) begin
      if (a_dr != last_a || b_dr != last_b) begin
         int nz;
         int n11;
         nz = 0;
         n11 = 0;
         for (int i = 0; i < 32; i++) begin
            if (a_dr[2*i +: 2] != 2'b00) nz++;
            if (b_dr[2*i +: 2] != 2'b00) nz++;
            if (a_dr[2*i +: 2] == 2'b11) n11++;
            if (b_dr[2*i +: 2] == 2'b11) n11++;
         end
         check("wavefront_shape", {31'd0, (n11 == 0 && (nz == 0 || nz == 64))}, 64'd1);
         if (nz == 64 && last_a == '0 && last_b == '0)
            obs_q.push_back({dec(a_dr), dec(b_dr)});
         last_a = a_dr;
         last_b = b_dr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns edges taken until a_dr matches the wanted data/null state.
   task automatic wait_dr(input bit want_data, input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (((a_dr != '0) != want_data) && n < limit);
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b, output bit ok);
      int t;
      t = 0;
      while (!in_ready && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      ok = in_ready;
      if (ok) begin
         in_a = a;
         in_b = b;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      init_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      init_n = 1'b1;
   endtask

   initial begin
      int n;
      bit ok;
      logic [31:0] ra, rb;

      tbl[0] = '{32'h00000000, 32'hFFFFFFFF, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};
      tbl[1] = '{32'h80000000, 32'h00000001, 64'h9555555555555555, 64'h5555555555555556};
      tbl[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 64'h9966996699669966, 64'h6699669966996699};
      tbl[3] = '{32'h12345678, 32'hFFFF0000, 64'h56595A6566696A95, 64'hAAAAAAAA55555555};
      tbl[4] = '{32'hDEADBEEF, 32'h00000000, 64'hA6A999A69AA9A9AA, 64'h5555555555555555};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_dr", a_dr, 0);
      check("rst_b_dr", b_dr, 0);
      check("rst_in_ready", {63'd0, in_ready}, 1);
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_wave_count", {48'd0, wave_count}, 0);
      check("rst_timeout_err", {63'd0, timeout_err}, 0);
      init_n = 1'b1;
      @(posedge clk); #1;

      // Directed first wavefront and ki-to-output latency
      push_pair(32'h00000001, 32'h00000003, ok);
      check("t1_busy_queued", {63'd0, busy}, 1);
      check("t1_still_null", a_dr, 0);
      ki_man = 1'b1;
      wait_dr(1'b1, 10, n);
      check("t1_data_latency", n, 3);
      check("t1_a_dr", a_dr, 64'h5555555555555556);
      check("t1_b_dr", b_dr, 64'h555555555555555A);
      ki_man = 1'b0;
      wait_dr(1'b0, 10, n);
      check("t1_null_latency", n, 3);
      check("t1_b_null", b_dr, 0);
      check("t1_wave_count", {48'd0, wave_count}, 1);
      ki_man = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t1_idle_busy", {63'd0, busy}, 0);

      // Table-driven encoding vectors with the adder model pacing ki
      model_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push_pair(tbl[k].a, tbl[k].b, ok);
         check("tbl_push_ok", {63'd0, ok}, 1);
         wait_dr(1'b1, 20, n);
         check($sformatf("tbl%0d_a_dr", k), a_dr, tbl[k].ea);
         check($sformatf("tbl%0d_b_dr", k), b_dr, tbl[k].eb);
         wait_dr(1'b0, 20, n);
      end

      // Random stream against an in-order queue model
      do_reset();
      obs_q.delete();
      exp_q.delete();
      for (int k = 0; k < 100; k++) begin
         ra = $urandom;
         rb = $urandom;
         push_pair(ra, rb, ok);
         if (!ok) check("rand_push_stall", 0, 1);
         else exp_q.push_back({ra, rb});
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      for (int t = 0; t < 3000 && wave_count != 16'd100; t++) begin
         @(posedge clk); #1;
      end
      check("rand_wave_count", {48'd0, wave_count}, 100);
      check("rand_obs_len", obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check($sformatf("rand_pair%0d", i), obs_q[i], exp_q[i]);

      // FIFO full with ki stuck at request-for-null
      model_en = 1'b0;
      ki_man = 1'b0;
      do_reset();
      obs_q.delete();
      exp_q.delete();
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_a = 32'd100 + k;
         in_b = 32'd200 + k;
         check($sformatf("full_rdy%0d", k), {63'd0, in_ready}, {63'd0, (k < 4)});
         if (k < 4) exp_q.push_back({in_a, in_b});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("full_rdy_after", {63'd0, in_ready}, 0);
      repeat (5) @(posedge clk);
      #1;
      check("full_out_null", a_dr | b_dr, 0);
      check("full_busy", {63'd0, busy}, 1);
      model_en = 1'b1;
      for (int t = 0; t < 300 && wave_count != 16'd4; t++) begin
         @(posedge clk); #1;
      end
      repeat (20) @(posedge clk);
      #1;
      check("full_wave_count", {48'd0, wave_count}, 4);
      check("full_obs_len", obs_q.size(), 4);
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check($sformatf("full_pair%0d", i), obs_q[i], exp_q[i]);

      // Timeout: DATA held because ki never requests NULL
      model_en = 1'b0;
      ki_man = 1'b1;
      do_reset();
      push_pair(32'h0000CAFE, 32'h0000BEEF, ok);
      wait_dr(1'b1, 10, n);
      check("to_data_seen", {63'd0, (a_dr != '0)}, 1);
      check("to_err_at_entry", {63'd0, timeout_err}, 0);
      n = 0;
      while (!timeout_err && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("to_err_cycles", n, 16);
      repeat (10) @(posedge clk);
      #1;
      check("to_err_sticky", {63'd0, timeout_err}, 1);
      check("to_data_held", {dec(a_dr), dec(b_dr)}, {32'h0000CAFE, 32'h0000BEEF});

      // Asynchronous reset in S_DATA with two entries queued
      push_pair(32'h1, 32'h2, ok);
      push_pair(32'h3, 32'h4, ok);
      check("mid_busy_pre", {63'd0, busy}, 1);
      init_n = 1'b0;
      #1;
      check("mid_a_dr", a_dr, 0);
      check("mid_b_dr", b_dr, 0);
      check("mid_in_ready", {63'd0, in_ready}, 1);
      check("mid_busy", {63'd0, busy}, 0);
      check("mid_wave_count", {48'd0, wave_count}, 0);
      check("mid_timeout_err", {63'd0, timeout_err}, 0);
      @(posedge clk); #1;
      init_n = 1'b1;

      // wave_count wrap from 0xFFFF
      model_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      force dut.wave_count = 16'hFFFF;
      @(posedge clk); #1;
      release dut.wave_count;
      @(posedge clk); #1;
      check("wrap_preload", {48'd0, wave_count}, 64'hFFFF);
      push_pair(32'h55, 32'hAA, ok);
      for (int t = 0; t < 100 && wave_count == 16'hFFFF; t++) begin
         @(posedge clk); #1;
      end
      check("wrap_zero", {48'd0, wave_count}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
